// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - register-file write-port arbiter with multi-cycle pending scoreboard
module rf_wb_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_valid,
  input  logic [4:0]            s0_rd,
  input  logic [DATA_WIDTH-1:0] s0_data,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [4:0]            s1_rd,
  input  logic [DATA_WIDTH-1:0] s1_data,
  output logic                  s1_ready,
  input  logic                  iss_valid,
  input  logic [4:0]            iss_rd,
  output logic                  iss_ready,
  input  logic [4:0]            chk_rs,
  input  logic [4:0]            chk_rt,
  output logic                  stall,
  output logic                  rf_we,
  output logic [4:0]            rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data
);

  // index of the source granted most recently; reset favours s0 on first contention
  logic                  last_grant;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_d;
  logic                  acc0;
  logic                  acc1;
  logic                  acc;
  logic                  iss_fire;
  logic [4:0]            win_rd;
  logic [DATA_WIDTH-1:0] win_data;

  // register 0 and unimplemented addresses are never written nor tracked
  function automatic logic in_range(input logic [4:0] a);
    return (a != 5'd0) && ({27'd0, a} < 32'(NUM_REGS));
  endfunction

  // out-of-range lookups read as not pending
  function automatic logic is_pending(input logic [4:0] a, input logic [NUM_REGS-1:0] p);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (in_range(a) && (a == 5'(i))) hit = p[i];
    end
    return hit;
  endfunction

  assign s0_ready  = !s1_valid || last_grant;
  assign s1_ready  = !s0_valid || !last_grant;
  assign acc0      = s0_valid && s0_ready;
  assign acc1      = s1_valid && s1_ready;
  assign acc       = acc0 || acc1;
  assign win_rd    = acc1 ? s1_rd : s0_rd;
  assign win_data  = acc1 ? s1_data : s0_data;
  assign iss_ready = !is_pending(iss_rd, pending);
  assign iss_fire  = iss_valid && iss_ready && in_range(iss_rd);
  assign stall     = is_pending(chk_rs, pending) || is_pending(chk_rt, pending);

  // scoreboard next state: s1 write-back clears, issue sets, set applied last so it wins
  always_comb begin
    pending_d = pending;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (acc1 && (s1_rd == 5'(i)))    pending_d[i] = 1'b0;
      if (iss_fire && (iss_rd == 5'(i))) pending_d[i] = 1'b1;
    end
  end

  // arbitration history and scoreboard state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      pending    <= '0;
    end else begin
      if (acc) last_grant <= acc1;
      pending <= pending_d;
    end
  end

  // registered write port; address/data hold when nothing is written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we   <= 1'b0;
      rf_rd   <= 5'd0;
      rf_data <= '0;
    end else begin
      rf_we <= acc && in_range(win_rd);
      if (acc && in_range(win_rd)) begin
        rf_rd   <= win_rd;
        rf_data <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - self-checking bench for rf_wb_scheduler
module tb_rf_wb_scheduler;
  localparam int DW = 32;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s0_valid, s1_valid, iss_valid;
  logic [4:0]    s0_rd, s1_rd, iss_rd, chk_rs, chk_rt;
  logic [DW-1:0] s0_data, s1_data;
  logic          s0_ready, s1_ready, iss_ready, stall, rf_we;
  logic [4:0]    rf_rd;
  logic [DW-1:0] rf_data;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_data(s1_data), .s1_ready(s1_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .stall(stall),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  bit            m_pend [32];
  int            m_lg;
  bit            m_we;
  logic [4:0]    m_rd;
  logic [DW-1:0] m_data;
  bit            last_acc0, last_acc1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit inr(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NR);
  endfunction

  function automatic bit busy(input logic [4:0] a);
    return inr(a) && m_pend[a];
  endfunction

  task automatic model_reset();
    m_lg = 1;
    m_we = 1'b0;
    m_rd = 5'd0;
    m_data = '0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
  endtask

  // one clock: compare at the falling edge, advance the model, return just after the rising edge
  task automatic step();
    int            gnt;
    bit            iok;
    logic [4:0]    wrd;
    logic [DW-1:0] wdata;
    @(negedge clk);
    if (s0_valid && s1_valid) gnt = 1 - m_lg;
    else if (s0_valid)        gnt = 0;
    else if (s1_valid)        gnt = 1;
    else                      gnt = -1;
    if (s0_valid) chk("s0_ready", 32'(s0_ready), 32'(gnt == 0));
    if (s1_valid) chk("s1_ready", 32'(s1_ready), 32'(gnt == 1));
    iok = !busy(iss_rd);
    chk("iss_ready", 32'(iss_ready), 32'(iok));
    chk("stall", 32'(stall), 32'(busy(chk_rs) || busy(chk_rt)));
    chk("rf_we", 32'(rf_we), 32'(m_we));
    if (m_we) begin
      chk("rf_rd", 32'(rf_rd), 32'(m_rd));
      chk("rf_data", rf_data, m_data);
    end
    last_acc0 = (gnt == 0);
    last_acc1 = (gnt == 1);
    if (gnt >= 0) begin
      m_lg  = gnt;
      wrd   = (gnt == 1) ? s1_rd : s0_rd;
      wdata = (gnt == 1) ? s1_data : s0_data;
      m_we  = inr(wrd);
      if (m_we) begin
        m_rd   = wrd;
        m_data = wdata;
      end
    end else begin
      m_we = 1'b0;
    end
    if (last_acc1 && inr(s1_rd)) m_pend[s1_rd] = 1'b0;
    if (iss_valid && iok && inr(iss_rd)) m_pend[iss_rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int i0, i1;
    int exp_seq [4];
    exp_seq = '{1, 9, 2, 10};
    rst = 1'b0;
    s0_valid = 0; s0_rd = 0; s0_data = 0;
    s1_valid = 0; s1_rd = 0; s1_data = 0;
    iss_valid = 0; iss_rd = 0; chk_rs = 0; chk_rt = 0;
    last_acc0 = 0; last_acc1 = 0;
    model_reset();
    #1;
    chk("reset_we", 32'(rf_we), 32'd0);
    chk("reset_rd", 32'(rf_rd), 32'd0);
    chk("reset_data", rf_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // contention, each source holds its offer until accepted
    i0 = 1; i1 = 9;
    for (int k = 0; k < 4; k++) begin
      s0_valid = 1; s0_rd = 5'(i0); s0_data = 32'(i0) * 32'h01010101;
      s1_valid = 1; s1_rd = 5'(i1); s1_data = 32'(i1) * 32'h00100100;
      step();
      chk("contention_rd", 32'(rf_rd), 32'(exp_seq[k]));
      if (last_acc0) i0++;
      if (last_acc1) i1++;
    end
    s0_valid = 0; s1_valid = 0;
    step();

    // single source write and its one-cycle pulse
    s0_valid = 1; s0_rd = 5'd5; s0_data = 32'hDEADBEEF;
    step();
    s0_valid = 0;
    chk("single_we", 32'(rf_we), 32'd1);
    chk("single_rd", 32'(rf_rd), 32'd5);
    chk("single_data", rf_data, 32'hDEADBEEF);
    step();
    chk("single_we_off", 32'(rf_we), 32'd0);

    // read-after-write and write-after-write on register 7
    iss_valid = 1; iss_rd = 5'd7;
    step();
    iss_valid = 0; chk_rs = 5'd7;
    #1;
    chk("raw_stall", 32'(stall), 32'd1);
    iss_valid = 1;
    #1;
    chk("waw_iss_ready", 32'(iss_ready), 32'd0);
    step();
    iss_valid = 0;
    s1_valid = 1; s1_rd = 5'd7; s1_data = 32'h0BADF00D;
    #1;
    chk("raw_stall_hold", 32'(stall), 32'd1);
    step();
    s1_valid = 0;
    #1;
    chk("raw_stall_clear", 32'(stall), 32'd0);
    chk("raw_wb_rd", 32'(rf_rd), 32'd7);

    // set/clear collision on register 3
    iss_valid = 1; iss_rd = 5'd3;
    step();
    s1_valid = 1; s1_rd = 5'd3; s1_data = 32'h33;
    #1;
    chk("collide_iss_blocked", 32'(iss_ready), 32'd0);
    step();
    iss_valid = 0; s1_valid = 0; chk_rs = 5'd3;
    #1;
    chk("collide_cleared", 32'(stall), 32'd0);
    iss_valid = 1; iss_rd = 5'd3; s1_valid = 1; s1_rd = 5'd3;
    #1;
    chk("collide_iss_ok", 32'(iss_ready), 32'd1);
    step();
    iss_valid = 0; s1_valid = 0;
    #1;
    chk("collide_set_wins", 32'(stall), 32'd1);
    s1_valid = 1;
    step();
    s1_valid = 0;

    // register 0 and out-of-range destinations
    s0_valid = 1; s0_rd = 5'd0; s0_data = 32'h11;
    s1_valid = 1; s1_rd = 5'd20; s1_data = 32'h22;
    for (int k = 0; k < 4 && (s0_valid || s1_valid); k++) begin
      step();
      chk("r0_oor_we", 32'(rf_we), 32'd0);
      if (last_acc0) s0_valid = 0;
      if (last_acc1) s1_valid = 0;
    end
    chk("r0_oor_drained", 32'(s0_valid || s1_valid), 32'd0);
    s0_valid = 0; s1_valid = 0;
    iss_valid = 1; iss_rd = 5'd0; chk_rs = 5'd0; chk_rt = 5'd0;
    #1;
    chk("r0_iss_ready", 32'(iss_ready), 32'd1);
    chk("r0_stall", 32'(stall), 32'd0);
    step();
    iss_valid = 0;
    #1;
    chk("r0_stall_after", 32'(stall), 32'd0);

    // asynchronous reset in the middle of a write
    s0_valid = 1; s0_rd = 5'd6; s0_data = 32'h66666666;
    iss_valid = 1; iss_rd = 5'd7;
    step();
    s0_valid = 0; iss_valid = 0; chk_rs = 5'd7;
    #1;
    chk("pre_reset_we", 32'(rf_we), 32'd1);
    chk("pre_reset_stall", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_reset_we", 32'(rf_we), 32'd0);
    chk("async_reset_rd", 32'(rf_rd), 32'd0);
    chk("async_reset_data", rf_data, 32'd0);
    chk("async_reset_stall", 32'(stall), 32'd0);
    model_reset();
    rst = 1'b1;
    #1;
    s0_valid = 1; s0_rd = 5'd2; s0_data = 32'h2;
    s1_valid = 1; s1_rd = 5'd11; s1_data = 32'hB;
    step();
    chk("post_reset_grant", 32'(rf_rd), 32'd2);
    s0_valid = 0;
    step();
    s1_valid = 0;

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if (!(s0_valid && !last_acc0)) begin
        s0_valid = ($urandom % 3) != 0;
        s0_rd    = 5'($urandom_range(0, 19));
        s0_data  = $urandom;
      end
      if (!(s1_valid && !last_acc1)) begin
        s1_valid = ($urandom % 3) != 0;
        s1_rd    = 5'($urandom_range(0, 17));
        s1_data  = $urandom;
      end
      iss_valid = ($urandom % 2) != 0;
      iss_rd    = 5'($urandom_range(0, 17));
      chk_rs    = 5'($urandom_range(0, 19));
      chk_rt    = 5'($urandom_range(0, 19));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-back scheduler for the 16-entry register file: shares its single write port between the single-cycle ALU result path (source 0) and the multi-cycle unit result path (source 1, mul/div/load). Tracks outstanding multi-cycle destinations in a pending scoreboard so the decode stage can stall on read-after-write and write-after-write hazards. Sits between the execute/memory stages and the register file's dataIn/we/rd inputs.

## Interface
- DATA_WIDTH, 32, width of write-back data
- NUM_REGS, 16, implemented register count; addresses >= NUM_REGS are not stored
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- s0_valid  in  1  ALU result valid
- s0_rd  in  5  ALU destination
- s0_data  in  DATA_WIDTH  ALU result
- s0_ready  out  1  ALU result accepted this cycle when high with s0_valid
- s1_valid, s1_rd, s1_data, s1_ready: same meanings for the multi-cycle unit
- iss_valid  in  1  multi-cycle op issuing this cycle
- iss_rd  in  5  its destination
- iss_ready  out  1  issue accepted when high with iss_valid
- chk_rs, chk_rt  in  5 each  decode-stage source addresses
- stall  out  1  pending[chk_rs] or pending[chk_rt] (combinational)
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  5  register-file write address (registered)
- rf_data  out  DATA_WIDTH  register-file write data (registered)

## Operation
- Reset (rst low, asynchronous): rf_we=0, rf_rd=0, rf_data=0, pending=all 0, last_grant=1; any write in flight is cancelled.
- Handshake: a transfer occurs on a rising edge where valid and ready are both high. Sources must hold rd/data stable while valid and not ready.
- Arbitration, at most one acceptance per cycle:
  - only one source valid: it is granted (ready high).
  - both valid: grant the source not in last_grant (round robin); the other's ready is low.
  - s0_ready = !s1_valid | (last_grant==1); s1_ready = !s0_valid | (last_grant==0).
  - last_grant updates to the granted index on every acceptance; unchanged on idle cycles.
- Write generation, on acceptance of rd/data:
  - rd==0 or rd>=NUM_REGS: transfer is consumed, rf_we=0 next cycle (register 0 reads as zero by never being written).
  - otherwise: rf_we=1, rf_rd=rd, rf_data=data next cycle.
  - no acceptance: rf_we=0; rf_rd/rf_data hold.
- Scoreboard (pending[0:NUM_REGS-1]):
  - iss_ready = !pending[iss_rd] (WAW stall); for iss_rd==0 or >=NUM_REGS iss_ready=1 and no bit is set.
  - accepted issue sets pending[iss_rd].
  - accepted s1 transfer clears pending[s1_rd].
  - same register set and cleared in one cycle: set wins.
  - s0 transfers never touch the scoreboard.
  - chk addresses 0 or >=NUM_REGS never stall.

## Timing
- Acceptance edge N -> rf_we/rf_rd/rf_data valid from edge N to edge N+1; the register file captures on the falling edge inside that cycle; value readable by a register-file read at edge N+2.
- pending bit clears at edge N (s1 accept), so stall drops in cycle N+1 and the dependent read at edge N+2 sees the new value.
- Scheduler latency: 1 cycle; throughput: 1 write per cycle.
- Starvation bound: under continuous contention each source is granted at least every second cycle.
- ready, iss_ready and stall are combinational from current inputs and state; no combinational path from inputs to rf_* outputs.

## Test plan
- Reset: drive rst low mid-write (rf_we=1) -> rf_we=0, rf_rd=0, rf_data=0, pending=0 immediately, without a clock edge; after release, first contention grants s0.
- Single source: s0 writes rd=5, data=0xDEADBEEF at edge N -> rf_we=1, rf_rd=5, rf_data=0xDEADBEEF during cycle N+1, rf_we=0 in N+2.
- Contention: both valid for 4 cycles (s0 rd=1..4, s1 rd=9..12, held until accepted) -> grants alternate s0,s1,s0,s1; rf_rd sequence 1,9,2,10.
- Scoreboard RAW: issue rd=7; chk_rs=7 -> stall=1 until s1 accepts rd=7 at edge N; stall=0 from cycle N+1; second issue to rd=7 while pending -> iss_ready=0.
- Set/clear collision: s1 accepts rd=3 in the same cycle as an issue to rd=3 (pending[3] already set) -> iss_ready=0, no issue; with pending[3] clear and s1 rd=3 plus issue rd=3 -> pending[3]=1 afterwards.
- Register 0 / out of range: s0 rd=0 and s1 rd=20 accepted -> rf_we stays 0; issue rd=0 -> iss_ready=1, stall on chk_rs=0 stays 0.
